// File: rtl/fifo_pkg.sv
// Shared helpers for the single- and dual-clock FIFOs.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
//
// Contents:
//   fifo_flags_t  registered status flag bundle
//   addr_width()  memory index width for a given depth (minimum 1)
//   x_to_zero()   sanitising function; maps any bit that is not a solid 1
//                 (0, X or Z) to 0. It works one bit at a time, so callers
//                 apply it across a word of any width.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Constant function: usable in localparam and port width expressions.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // A 4-state case compare is used so that X/Z read from never-written
    // memory cannot leak downstream as unknowns.
    function automatic logic x_to_zero(input logic b);
        return (b === 1'b1) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Latency: read data appears on rd_data one clock after rd_en.
// Backpressure: none; the owner decides when ports may be used.
//
// Ports:
//   clock              sole clock
//   wr_en/wr_addr/wr_data  write port, written on the rising edge
//   rd_en/rd_addr      read port; rd_data updates on the edge where rd_en=1
//   rd_clr             synchronous clear of the read register to 0
//                      (has priority over rd_en); memory is not cleared
//   rd_data            registered read data
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors, flush.
// Latency: standard mode dout valid the edge after an accepted read; FWFT mode
//          a write into an empty FIFO is visible on dout two edges later.
// Backpressure: writes dropped while full (overflow), reads dropped while empty
//          (underflow); both flags are registered at the start of the cycle.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (dout always shows the head word, empty=0 means dout is valid, rd_en pops).
// Leave it undefined for standard registered-read mode.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous active-low reset (priority over clear)
//   clear          synchronous flush; ignores wr_en/rd_en in the same cycle
//   wr_en, din     write request and data
//   rd_en          read request / pop
//   dout           read data, X/Z bits forced to 0
//   full, empty, almost_full, almost_empty   registered status flags
//   count          occupancy 0..FIFO_BUFFER_SIZE
//   overflow, underflow                      sticky error flags
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 32,
    parameter int FIFO_BUFFER_SIZE = 16,
    parameter int AF_THRESH        = FIFO_BUFFER_SIZE - 2,
    parameter int AE_THRESH        = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0]             din,
    input  logic                                   rd_en,
    output logic [FIFO_DATA_WIDTH-1:0]             dout,
    output logic                                   full,
    output logic                                   empty,
    output logic                                   almost_full,
    output logic                                   almost_empty,
    output logic [addr_width(FIFO_BUFFER_SIZE):0]  count,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int ADDR_W = addr_width(FIFO_BUFFER_SIZE);
    localparam int CNT_W  = ADDR_W + 1;

    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  (AF_THRESH <= 0),
        almost_empty: (AE_THRESH >= 0)
    };

    // Pointers carry one extra wrap bit; the low ADDR_W bits address memory.
    logic [ADDR_W:0]            wr_ptr;
    logic [ADDR_W:0]            rd_ptr;
    fifo_flags_t                flags_q;
    fifo_flags_t                flags_nxt;
    logic [CNT_W-1:0]           count_nxt;
    logic                       wr_acc;
    logic                       rd_acc;
    logic                       ram_rd;
    logic                       ram_clr;
    logic [FIFO_DATA_WIDTH-1:0] ram_q;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // full FIFO with both requests drains one word and rejects the write, and
    // an empty FIFO with both requests takes the write and rejects the read.
    assign wr_acc  = wr_en & ~flags_q.full  & ~clear;
    assign rd_acc  = rd_en & ~flags_q.empty & ~clear;
    assign ram_clr = ~reset | clear;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CNT_W'(1);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the output stage. out_vld says it
    // holds the head word; count covers it as well as the words still in RAM.
    logic out_vld;
    logic out_vld_nxt;
    logic ram_nonempty;

    assign ram_nonempty = (wr_ptr != rd_ptr);
    // Prefetch whenever the output stage is empty or is being popped.
    assign ram_rd       = ~clear & ram_nonempty & (~out_vld | rd_acc);
    assign out_vld_nxt  = ram_rd | (out_vld & ~rd_acc);
`else
    assign ram_rd = rd_acc;
`endif

    always_comb begin
        flags_nxt              = FLAGS_RST;
        flags_nxt.full         = (count_nxt == CNT_W'(FIFO_BUFFER_SIZE));
        flags_nxt.almost_full  = (int'(count_nxt) >= AF_THRESH);
        flags_nxt.almost_empty = (int'(count_nxt) <= AE_THRESH);
`ifdef SYNC_FIFO_FWFT_EN
        // Empty tracks the output stage: a freshly written word is counted
        // immediately but only becomes readable once it has been prefetched.
        flags_nxt.empty        = ~out_vld_nxt;
`else
        flags_nxt.empty        = (count_nxt == '0);
`endif
    end

    // Reset and clear share one branch: both return the same state, so the
    // reset-over-clear priority holds trivially. Memory contents are kept.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flags_q   <= FLAGS_RST;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
            out_vld   <= 1'b0;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
            count   <= count_nxt;
            flags_q <= flags_nxt;
            if (wr_en && flags_q.full) begin
                overflow <= 1'b1;
            end
            if (rd_en && flags_q.empty) begin
                underflow <= 1'b1;
            end
`ifdef SYNC_FIFO_FWFT_EN
            out_vld <= out_vld_nxt;
`endif
        end
    end

    fifo_ram #(
        .DATA_W (FIFO_DATA_WIDTH),
        .DEPTH  (FIFO_BUFFER_SIZE),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (din),
        .rd_en   (ram_rd),
        .rd_clr  (ram_clr),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    always_comb begin
        dout = '0;
        for (int i = 0; i < FIFO_DATA_WIDTH; i++) begin
            dout[i] = x_to_zero(ram_q[i]);
        end
    end

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;

endmodule
